// File: rtl/fp_acc.sv
// Streaming float accumulator: sums each data_last-delimited vector of products
// and holds one [s][EXP][MANT] result per vector. Define FP_ACC_COUNT_EN for result_count.
module fp_acc #(
  parameter int EXP   = 5,
  parameter int MANT  = 10,
  parameter int WIDTH = EXP + MANT + 1,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clock_areset_n,
  input  logic             clear,
  input  logic             data_valid,
  input  logic             data_last,
  input  logic [WIDTH-1:0] data,
  output logic             data_ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             saturated
`ifdef FP_ACC_COUNT_EN
  ,
  output logic [CNT_W-1:0] result_count
`endif
);

  localparam int MW  = MANT + 1;          // mantissa including hidden bit
  localparam int LZW = $clog2(MW + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc;
  logic               sat_sticky;
  logic               accept;

  // fpadd datapath
  logic               a_zero, b_zero, a_big, big_s;
  logic [EXP+MANT-1:0] a_mag, b_mag;
  logic [EXP-1:0]     big_e, small_e, ediff;
  logic [MW-1:0]      big_m, small_m, small_sh, dif;
  logic [MW:0]        sum;
  logic [LZW-1:0]     lzc;
  logic               lz_found;
  logic [MANT-1:0]    norm;
  logic [EXP:0]       e_up;
  logic [WIDTH-1:0]   add_res;
  logic               add_ovf;

  always_comb begin
    a_mag    = acc[WIDTH-2:0];
    b_mag    = data[WIDTH-2:0];
    a_zero   = (a_mag == '0);
    b_zero   = (b_mag == '0);
    a_big    = (a_mag >= b_mag);
    big_s    = a_big ? acc[WIDTH-1] : data[WIDTH-1];
    big_e    = a_big ? a_mag[EXP+MANT-1:MANT] : b_mag[EXP+MANT-1:MANT];
    small_e  = a_big ? b_mag[EXP+MANT-1:MANT] : a_mag[EXP+MANT-1:MANT];
    big_m    = {1'b1, (a_big ? a_mag[MANT-1:0] : b_mag[MANT-1:0])};
    small_m  = {1'b1, (a_big ? b_mag[MANT-1:0] : a_mag[MANT-1:0])};
    ediff    = big_e - small_e;
    // shifts past the mantissa width naturally yield zero
    small_sh = small_m >> ediff;
    sum      = {1'b0, big_m} + {1'b0, small_sh};
    dif      = big_m - small_sh;

    lzc      = '0;
    lz_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (dif[i]) lz_found = 1'b1;
        else        lzc = lzc + LZW'(1);
      end
    end
    norm = MANT'(dif << lzc);
    e_up = {1'b0, big_e} + (EXP+1)'(sum[MW]);

    add_ovf = 1'b0;
    if (b_zero)
      add_res = acc;
    else if (a_zero)
      add_res = data;
    else if (acc[WIDTH-1] == data[WIDTH-1]) begin
      if (e_up[EXP]) begin
        add_res = {big_s, {EXP{1'b1}}, {MANT{1'b1}}};
        add_ovf = 1'b1;
      end else begin
        add_res = {big_s, e_up[EXP-1:0], (sum[MW] ? sum[MANT:1] : sum[MANT-1:0])};
      end
    end else if (dif == '0 || {1'b0, big_e} < (EXP+1)'(lzc))
      add_res = '0;                       // exact cancel or underflow flushes to +0
    else
      add_res = {big_s, big_e - EXP'(lzc), norm};
  end

  // control FSM
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) state_q <= ACCUM;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = ACCUM;
    else begin
      case (state_q)
        ACCUM:   if (accept && data_last) state_d = HOLD;
        HOLD:    if (result_valid && result_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    data_ready = (state_q == ACCUM);
  end

  assign accept = data_valid & data_ready;

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      acc          <= '0;
      sat_sticky   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      saturated    <= 1'b0;
    end else if (clear) begin
      acc          <= '0;
      sat_sticky   <= 1'b0;
      result_valid <= 1'b0;
    end else if (accept) begin
      if (data_last) begin
        result       <= add_res;
        saturated    <= sat_sticky | add_ovf;
        result_valid <= 1'b1;
        acc          <= '0;
        sat_sticky   <= 1'b0;
      end else begin
        acc          <= add_res;
        sat_sticky   <= sat_sticky | add_ovf;
      end
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

`ifdef FP_ACC_COUNT_EN
  logic [CNT_W-1:0] cnt, cnt_inc;
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      cnt          <= '0;
      result_count <= '0;
    end else if (clear) begin
      cnt          <= '0;
    end else if (accept) begin
      if (data_last) begin
        result_count <= cnt_inc;
        cnt          <= '0;
      end else begin
        cnt          <= cnt_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_acc.sv
// Directed bench for fp_acc (EXP=5, MANT=10) with hand-computed sums.
module tb_fp_acc;
  localparam int W = 16;

  logic         clock = 1'b0;
  logic         clock_areset_n;
  logic         clear, data_valid, data_last, result_ready;
  logic [W-1:0] data;
  logic         data_ready, result_valid, saturated;
  logic [W-1:0] result;
`ifdef FP_ACC_COUNT_EN
  logic [15:0]  result_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fp_acc dut (
    .clock          (clock),
    .clock_areset_n (clock_areset_n),
    .clear          (clear),
    .data_valid     (data_valid),
    .data_last      (data_last),
    .data           (data),
    .data_ready     (data_ready),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result         (result),
    .saturated      (saturated)
`ifdef FP_ACC_COUNT_EN
    ,
    .result_count   (result_count)
`endif
  );

  // Offer one element; waits (bounded) for data_ready, returns #1 after the accepting edge.
  task automatic push(input logic [W-1:0] d, input logic l);
    int n = 0;
    data = d; data_last = l; data_valid = 1'b1;
    while (!data_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    n_checks++;
    if (!data_ready) begin
      n_fail++;
      $display("FAIL push_timeout: data_ready=%0b required 1", data_ready);
    end
    @(posedge clock); #1;
    data_valid = 1'b0; data_last = 1'b0;
  endtask

  // Two-element vector, captures result right after the last element is accepted.
  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic s, output logic v);
    push(a, 1'b0);
    push(b, 1'b1);
    r = result; s = saturated; v = result_valid;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    clock_areset_n = 1'b0; clear = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    data = '0; result_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({result_valid, saturated, result} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b sat=%0b result=%h required 0", result_valid, saturated, result);
    end
    n_checks++;
    if (data_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: %0b required 1", data_ready);
    end
    clock_areset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    push(16'h3C00, 1'b0);
    push(16'h4000, 1'b1);
    n_checks++;
    if (result_valid !== 1'b1 || result !== 16'h4200 || saturated !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: valid=%0b result=%h sat=%0b required 1 4200 0", result_valid, result, saturated);
    end
    n_checks++;
    if (data_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_low: %0b required 0", data_ready);
    end
    @(posedge clock); #1;
    n_checks++;
    if (result_valid !== 1'b0 || data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: valid=%0b ready=%0b required 0 1", result_valid, data_ready);
    end
  endtask

  task automatic test_arith;
    logic [W-1:0] va[6], vb[6], exp_r[6];
    logic [W-1:0] r;
    logic s, v;
    va = '{16'h3C00, 16'h4000, 16'h0000, 16'h6000, 16'h0401, 16'h0001};
    vb = '{16'hBC00, 16'hB800, 16'h8000, 16'h0400, 16'h8400, 16'h0001};
    exp_r = '{16'h0000, 16'h3E00, 16'h0000, 16'h6000, 16'h0000, 16'h0401};
    for (int i = 0; i < 6; i++) begin
      run_vec(va[i], vb[i], r, s, v);
      n_checks++;
      if (v !== 1'b1 || r !== exp_r[i] || s !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_%0d (%h+%h): valid=%0b result=%h sat=%0b required 1 %h 0",
                 i, va[i], vb[i], v, r, s, exp_r[i]);
      end
    end
  endtask

  task automatic test_saturate;
    logic [W-1:0] r;
    logic s, v;
    run_vec(16'h7C00, 16'h7C00, r, s, v);
    n_checks++;
    if (r !== 16'h7FFF || s !== 1'b1 || v !== 1'b1) begin
      n_fail++; $display("FAIL saturate: result=%h sat=%0b required 7fff 1", r, s);
    end
    push(16'h3C00, 1'b1);
    n_checks++;
    if (result !== 16'h3C00 || saturated !== 1'b0) begin
      n_fail++; $display("FAIL sat_next: result=%h sat=%0b required 3c00 0", result, saturated);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure;
    result_ready = 1'b0;
    push(16'h3C00, 1'b0);
    push(16'h3C00, 1'b1);
    data = 16'h3C00; data_valid = 1'b1; data_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (result_valid !== 1'b1 || result !== 16'h4000 || data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: valid=%0b result=%h ready=%0b required 1 4000 0",
                 i, result_valid, result, data_ready);
      end
      @(posedge clock); #1;
    end
    result_ready = 1'b1;
    @(posedge clock); #1;
    data_valid = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0 || data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: valid=%0b ready=%0b required 0 1", result_valid, data_ready);
    end
    push(16'h3800, 1'b1);
    n_checks++;
    if (result !== 16'h3800) begin
      n_fail++; $display("FAIL hold_no_accept: result=%h required 3800", result);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_clear;
    push(16'h3C00, 1'b0);
    clear = 1'b1; data = 16'h4000; data_last = 1'b1; data_valid = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0 || data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_drop: valid=%0b ready=%0b required 0 1", result_valid, data_ready);
    end
    push(16'h3800, 1'b1);
    n_checks++;
    if (result !== 16'h3800 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL clear_sum: result=%h valid=%0b required 3800 1", result, result_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset;
    result_ready = 1'b0;
    push(16'h7C00, 1'b0);
    push(16'h7C00, 1'b1);
    #2 clock_areset_n = 1'b0;
    #1;
    n_checks++;
    if ({result_valid, saturated, result} !== 18'h0 || data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_held: valid=%0b sat=%0b result=%h ready=%0b required 0 0 0000 1",
               result_valid, saturated, result, data_ready);
    end
    @(posedge clock); #1;
    clock_areset_n = 1'b1; result_ready = 1'b1;
    push(16'h3C00, 1'b0);
    #2 clock_areset_n = 1'b0;
    #1;
    n_checks++;
    if ({result_valid, saturated, result} !== 18'h0) begin
      n_fail++;
      $display("FAIL areset_mid: valid=%0b sat=%0b result=%h required 0", result_valid, saturated, result);
    end
    @(posedge clock); #1;
    clock_areset_n = 1'b1;
    push(16'h3800, 1'b1);
    n_checks++;
    if (result !== 16'h3800) begin
      n_fail++; $display("FAIL areset_fresh: result=%h required 3800", result);
    end
    @(posedge clock); #1;
  endtask

`ifdef FP_ACC_COUNT_EN
  task automatic test_count;
    for (int i = 0; i < 6; i++) push(16'h0000, 1'b0);
    push(16'h0000, 1'b1);
    n_checks++;
    if (result_count !== 16'd7) begin
      n_fail++; $display("FAIL count_7: %0d required 7", result_count);
    end
    @(posedge clock); #1;
    push(16'h3C00, 1'b1);
    n_checks++;
    if (result_count !== 16'd1) begin
      n_fail++; $display("FAIL count_1: %0d required 1", result_count);
    end
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_saturate();
    test_backpressure();
    test_clear();
    test_async_reset();
`ifdef FP_ACC_COUNT_EN
    test_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_acc.md
Name: fp_acc

Overview:
- Streaming floating-point accumulator; sits directly downstream of the fp multiplier and consumes its product stream.
- Sums a vector of products delimited by data_last and emits one float per vector, e.g. a dot-product or convolution window sum.
- Same non-compliant format as the multiplier: [s][EXP][MANT], implied leading 1 unless exponent and mantissa bits are all zero, no NaN/Inf/denormals.
- Output handshake with backpressure.

Parameters:
- EXP, 5, exponent width
- MANT, 10, mantissa width
- WIDTH, EXP+MANT+1, float width
- CNT_W, 16, element-counter width (optional feature only)

Ports:
- clock  in  1  system clock
- clock_areset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: discard partial sum and any held result
- data_valid  in  1  input element valid
- data_last  in  1  marks final element of vector; qualified by data_valid
- data  in  WIDTH  product from multiplier
- data_ready  out  1  accumulator can accept data this cycle
- result_valid  out  1  result held
- result_ready  in  1  consumer accepts result
- result  out  WIDTH  vector sum
- saturated  out  1  sum of the presented vector clipped at any step

Behaviour:
- Reset (async assert, sync release): acc=+0 (all zero), state=ACCUM, result=0, result_valid=0, saturated=0, sat_sticky=0.
- Data handshake: data_ready = (state==ACCUM). An element is accepted when data_valid&data_ready.
- Accept, not last: acc <= fpadd(acc,data) next edge; sat_sticky |= step overflow.
- Accept with last:
  - result <= fpadd(acc,data); saturated <= sat_sticky|step overflow.
  - result_valid <= 1; acc <= +0; sat_sticky <= 0; state <= HOLD.
  - Latency is 1 cycle from accepting last to result_valid.
- Single-element vector (last on first element): result = data (fpadd(+0,x)=x).
- HOLD: data_ready=0. On result_valid&result_ready: result_valid <= 0, state <= ACCUM; data_ready is high again the next cycle.
- No same-cycle bypass from HOLD to accepting data.
- clear (priority over everything except reset): acc <= +0, sat_sticky <= 0, result_valid <= 0, state <= ACCUM. Data presented that cycle is dropped.
- fpadd, single cycle, combinational into the acc register:
  - Zero operand: bits WIDTH-2:0 all zero, sign ignored. If one operand is zero, result = other operand exactly.
  - Ordering: big = larger magnitude, compared on {exp,mant}. Result sign = sign of big.
  - Alignment: small mantissa (with hidden 1) right-shifted by exp difference; shifted-out bits truncated. A difference > MANT+1 leaves big unchanged.
  - Same signs: add. On carry-out, shift right 1 (truncate) and exp+1.
  - Opposite signs: subtract. A zero difference gives +0 (0x...0). Otherwise normalise left by leading-zero count; exp -= lzc.
  - Underflow: exponent below 0 after normalisation flushes to +0, no flag.
  - Overflow: exponent above 2^EXP-1 saturates to sign,{EXP{1}},{MANT{1}} and flags step overflow.
  - Exponent 0 with nonzero mantissa is a normal value.
  - Rounding is truncation only.

Optional Feature:
- FP_ACC_COUNT_EN defined: adds output result_count [CNT_W-1:0].
  - Internal counter increments per accepted element and saturates at all-ones.
  - Loaded into result_count together with result on last; counter clears on last, clear and reset.
  - result_count resets to 0 and is stable while result_valid.
- Undefined: no port and no counter logic.

Test Plan:
- EXP=5,MANT=10: 0x3C00, 0x4000(last), result_ready=1 -> result_valid one cycle after last, result=0x4200, saturated=0, data_ready low one cycle.
- 0x3C00, 0xBC00(last) -> result=0x0000. 0x4000, 0xB800(last) -> result=0x3E00. 0x0000, 0x8000(last) -> 0x0000.
- 0x7C00, 0x7C00(last) -> result=0x7FFF, saturated=1. Next vector 0x3C00(last) -> result=0x3C00, saturated=0.
- result_ready=0 for 5 cycles after result_valid -> result and result_valid stable, data_ready=0, offered data not accepted. Release -> data_ready=1 next cycle.
- 0x3C00, then clear, then 0x3800(last) -> result=0x3800. Assert clock_areset_n=0 mid-vector -> all outputs 0 immediately; next vector sums from +0.
- FP_ACC_COUNT_EN: 7-element vector -> result_count=7; single-element vector -> 1.
